muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and HI/LO width, even, at least 4.
REQ-002 The block SHALL have parameter CNT_W, default 6: iteration counter width, at least clog2(WIDTH+1).
REQ-003 Port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request a new operation this cycle.
REQ-006 Port op, input, 2 bits: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-007 Port operand_a, input, WIDTH bits: multiplicand or dividend (rs).
REQ-008 Port operand_b, input, WIDTH bits: multiplier or divisor (rt).
REQ-009 Port flush, input, 1 bit: abort the in-flight operation (pipeline flush).
REQ-010 Port hi_we, input, 1 bit: MTHI write strobe.
REQ-011 Port lo_we, input, 1 bit: MTLO write strobe.
REQ-012 Port wdata, input, WIDTH bits: MTHI/MTLO data.
REQ-013 Port hi_rd, input, 1 bit: MFHI or MFLO in decode this cycle.
REQ-014 Port busy, output, 1 bit: operation in flight.
REQ-015 Port done, output, 1 bit: one-cycle pulse when HI/LO take a result.
REQ-016 Port stall_req, output, 1 bit: freeze PC and IF/ID this cycle.
REQ-017 Port div_zero, output, 1 bit: sticky flag, last division had divisor 0.
REQ-018 Port hi, output, WIDTH bits: HI register.
REQ-019 Port lo, output, WIDTH bits: LO register.

Function
REQ-020 FSM SHALL have three states: IDLE, RUN, FIX. IDLE->RUN on start; RUN->FIX when counter reaches WIDTH; FIX->IDLE unconditionally.
REQ-021 start SHALL be accepted only in IDLE; start in RUN or FIX SHALL be ignored with no effect.
REQ-022 On acceptance, the block SHALL latch op, sign information, and magnitudes of operand_a/operand_b (two's-complement absolute value for signed ops; raw for unsigned), and clear the counter.
REQ-023 In RUN, the block SHALL perform one radix-2 step per cycle: shift-add for multiply (2*WIDTH product), restoring shift-subtract for divide; counter +1 per step.
REQ-024 In FIX, the block SHALL apply sign correction and write HI/LO: multiply HI=product[2W-1:W], LO=product[W-1:0], negated if operand signs differ (signed only); divide LO=quotient negated if signs differ, HI=remainder carrying the dividend's sign.
REQ-025 Latency SHALL be exact: start sampled at edge k -> HI/LO updated and done=1 after edge k+WIDTH+1; busy=1 after edges k..k+WIDTH, 0 after edge k+WIDTH+1.
REQ-026 done SHALL be high for exactly one cycle per completed operation and never for an aborted one.
REQ-027 Divide by zero: full latency, LO=all ones, HI=operand_a as issued, div_zero set; any other completed division clears div_zero.
REQ-028 Signed DIV of most-negative by -1 SHALL give LO=most-negative, HI=0, no flag.
REQ-029 flush SHALL force IDLE on the next edge from any state; HI/LO/div_zero unchanged; start in the same cycle ignored.
REQ-030 hi_we/lo_we SHALL write wdata in IDLE only and SHALL be ignored in RUN/FIX; in IDLE with start in the same cycle, the write SHALL occur and the operation SHALL also start.
REQ-031 stall_req SHALL be combinational and equal (busy & (hi_rd | start)) | (busy & (hi_we | lo_we)).
REQ-032 WIDTH-bit results SHALL be modulo 2^WIDTH; no overflow flag.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, regardless of clock.
REQ-034 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after release SHALL behave as from power-up.

Verification (WIDTH=32)
REQ-035 MULT with a=-3 (0xFFFFFFFD), b=7 -> done 33 edges after start, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 MULTU with a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
REQ-037 DIV with a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU with a=5, b=0 -> LO=0xFFFFFFFF, HI=5, div_zero=1.
REQ-038 DIV with a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
REQ-039 Start MULT, assert flush on cycle 10 -> busy 0 next cycle, no done, HI/LO unchanged; start plus hi_rd during RUN -> stall_req=1, second start ignored.
REQ-040 Assert reset_n low between edges mid-RUN -> busy, hi, lo read 0 immediately without a clock edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one step per cycle, with sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_rd,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               accept, last_step;

    assign busy      = (state != IDLE);
    assign stall_req = busy & (hi_rd | start | hi_we | lo_we);
    assign accept    = (state == IDLE) & start & ~flush;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // op[0] set means unsigned, so sign bits only matter for op[0]=0
    assign sgn_a = ~op[0] & operand_a[WIDTH-1];
    assign sgn_b = ~op[0] & operand_b[WIDTH-1];
    assign abs_a = sgn_a ? -operand_a : operand_a;
    assign abs_b = sgn_b ? -operand_b : operand_b;

    // acc holds {partial product, multiplier} or {remainder, quotient}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, opnd} : '0);
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};

    always_comb begin
        acc_step = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH])
                acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_n = RUN;
                RUN:     if (last_step) state_n = FIX;
                FIX:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (accept) begin
                is_div <= op[1];
                neg_q  <= sgn_a ^ sgn_b;
                neg_r  <= sgn_a;
                b_zero <= (operand_b == '0);
                opnd   <= op[1] ? abs_b : abs_a;
                acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                cnt    <= '0;
            end else if (state == RUN && !flush) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX && !flush) begin
                done <= 1'b1;
                if (is_div) begin
                    // zero divisor leaves remainder equal to the dividend
                    lo       <= b_zero ? '1 : quo_fix;
                    hi       <= rem_fix;
                    div_zero <= b_zero;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule
